// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases N_DOM active-low domain resets in ascending order at fixed spacing
// after power-on and PLL lock, with lock-loss recovery and masked software re-reset.
module rst_seq_ctrl #(
  parameter int N_DOM       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POR_CYCLES  = 16,
  parameter int STEP_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             RSTn,
  input  logic             lock_in,
  input  logic             soft_rst_req,
  input  logic [N_DOM-1:0] soft_rst_mask,
  output logic [N_DOM-1:0] rst_n_out,
  output logic             rst_done,
  output logic [2:0]       seq_state
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    SEQ       = 3'd2,
    RUN       = 3'd3,
    SOFT      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_sync_n;
  logic                   lock_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_DOM-1:0] pend_q, pend_d;
  logic [N_DOM-1:0] mask_q, mask_d;
  logic             req_q;
  logic [N_DOM-1:0] rst_out_q, rst_out_d;
  logic             done_q, done_d;

  logic             req_edge;
  logic [N_DOM-1:0] low_bit;
  logic [N_DOM-1:0] rel_mask;

  // Reset release is synchronised; assertion stays fully asynchronous.
  always_ff @(posedge clk_in or negedge RSTn) begin
    if (!RSTn) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_in or negedge RSTn) begin
    if (!RSTn) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock_in};
    end
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];
  assign lock_s     = lock_sync_q[SYNC_STAGES-1];

  assign req_edge = soft_rst_req & ~req_q;
  // Lowest pending domain is the next one to release, so skipped domains cost no time.
  assign low_bit  = pend_q & (~pend_q + N_DOM'(1));
  assign rel_mask = ((state_q == SEQ) && (cnt_q == STEP_LAST)) ? low_bit : '0;

  always_ff @(posedge clk_in or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      req_q     <= 1'b0;
      rst_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      req_q     <= soft_rst_req;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
    unique case (state_q)
      HOLD: begin
        if (rst_sync_n) begin
          if (cnt_q == POR_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_LOCK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = SEQ;
          cnt_d   = '0;
          pend_d  = '1;
        end
      end
      SEQ: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          pend_d  = '0;
        end else if (pend_q == '0) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d  = '0;
          pend_d = pend_q & ~low_bit;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          pend_d  = '0;
        end else if (req_edge && (soft_rst_mask != '0)) begin
          state_d = SOFT;
          cnt_d   = '0;
          mask_d  = soft_rst_mask;
        end
      end
      SOFT: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          pend_d  = '0;
        end else if (cnt_q == STEP_LAST) begin
          state_d = SEQ;
          cnt_d   = '0;
          pend_d  = mask_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
  end

  // Within SEQ the outputs only ever gain set bits, so releases are monotonic.
  always_comb begin
    rst_out_d = rst_out_q;
    done_d    = (state_d == RUN);
    unique case (state_d)
      HOLD, WAIT_LOCK: rst_out_d = '0;
      SEQ:             rst_out_d = rst_out_q | rel_mask;
      RUN:             rst_out_d = '1;
      SOFT:            rst_out_d = (state_q == RUN) ? ~soft_rst_mask : rst_out_q;
      default:         rst_out_d = '0;
    endcase
  end

  assign rst_n_out = rst_out_q;
  assign rst_done  = done_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: directed timing scenarios plus randomized lock/soft-reset traffic,
// all checked against an event-timed behavioural model of the sequencer.
module tb_rst_seq_ctrl;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int POR  = 16;
  localparam int STEP = 8;

  localparam int M_HOLD = 0;
  localparam int M_WAIT = 1;
  localparam int M_SEQ  = 2;
  localparam int M_RUN  = 3;
  localparam int M_SOFT = 4;

  logic         clk_in;
  logic         RSTn;
  logic         lock_in;
  logic         soft_rst_req;
  logic [N-1:0] soft_rst_mask;
  logic [N-1:0] rst_n_out;
  logic         rst_done;
  logic [2:0]   seq_state;

  int totalChecks = 0;
  int badChecks   = 0;

  // Model state: phase, edge count since reset release, absolute edge of next timed event.
  int           mPhase;
  int           edgeN;
  int           nextEvt;
  bit           mLockQ[$];
  int           pendQ[$];
  logic [N-1:0] mOut;
  logic [N-1:0] savedMask;
  bit           mPrevReq;

  int lockOff = 0;
  int reqHold = 0;

  rst_seq_ctrl #(
    .N_DOM(N), .SYNC_STAGES(SYNC), .POR_CYCLES(POR), .STEP_CYCLES(STEP), .CNT_W(8)
  ) dut (
    .clk_in       (clk_in),
    .RSTn         (RSTn),
    .lock_in      (lock_in),
    .soft_rst_req (soft_rst_req),
    .soft_rst_mask(soft_rst_mask),
    .rst_n_out    (rst_n_out),
    .rst_done     (rst_done),
    .seq_state    (seq_state)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mPhase   = M_HOLD;
    edgeN    = 0;
    nextEvt  = 0;
    mOut     = '0;
    mPrevReq = 1'b0;
    pendQ.delete();
    mLockQ.delete();
    for (int i = 0; i < SYNC; i++) mLockQ.push_back(1'b0);
  endfunction

  function automatic void startSeq(input logic [N-1:0] m);
    mPhase = M_SEQ;
    pendQ.delete();
    for (int i = 0; i < N; i++) if (m[i]) pendQ.push_back(i);
    nextEvt = edgeN + STEP;
  endfunction

  function automatic void modelEdge();
    bit ls;
    bit rise;
    if (!RSTn) return;
    edgeN++;
    ls = mLockQ.pop_front();
    mLockQ.push_back(lock_in);
    rise     = soft_rst_req && !mPrevReq;
    mPrevReq = soft_rst_req;
    if (mPhase == M_HOLD) begin
      if (edgeN == SYNC + POR) mPhase = M_WAIT;
    end else if (mPhase == M_WAIT) begin
      if (ls) startSeq('1);
    end else if (!ls) begin
      mPhase = M_WAIT;
      mOut   = '0;
      pendQ.delete();
    end else if (mPhase == M_SEQ) begin
      if (pendQ.size() == 0) mPhase = M_RUN;
      else if (edgeN == nextEvt) begin
        mOut[pendQ.pop_front()] = 1'b1;
        nextEvt = edgeN + STEP;
      end
    end else if (mPhase == M_RUN) begin
      if (rise && soft_rst_mask != '0) begin
        mPhase    = M_SOFT;
        savedMask = soft_rst_mask;
        mOut      = mOut & ~soft_rst_mask;
        nextEvt   = edgeN + STEP;
      end
    end else begin
      if (edgeN == nextEvt) startSeq(savedMask);
    end
  endfunction

  task automatic tick();
    @(posedge clk_in);
    modelEdge();
    #1;
    checkOutput("rstOut", 32'(rst_n_out), 32'(mOut));
    checkOutput("done",   32'(rst_done),  32'(mPhase == M_RUN));
    checkOutput("state",  32'(seq_state), 32'(mPhase));
  endtask

  task automatic holdReset();
    RSTn = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncOut",   32'(rst_n_out), 32'h0);
    checkOutput("asyncDone",  32'(rst_done),  32'h0);
    checkOutput("asyncState", 32'(seq_state), 32'h0);
    repeat (3) tick();
  endtask

  task automatic runColdStart(input bit lateLock);
    lock_in = !lateLock;
    RSTn    = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (lateLock && e == 40) lock_in = 1'b1;
      if (!lateLock) begin
        if (e == 17) checkOutput("coldHold17", 32'(seq_state), 32'd0);
        if (e == 18) checkOutput("coldWait18", 32'(seq_state), 32'd1);
        if (e == 19) checkOutput("coldSeq19",  32'(seq_state), 32'd2);
        if (e == 26) checkOutput("coldOut26",  32'(rst_n_out), 32'h0);
        if (e == 27) checkOutput("coldOut27",  32'(rst_n_out), 32'h1);
        if (e == 35) checkOutput("coldOut35",  32'(rst_n_out), 32'h3);
        if (e == 43) checkOutput("coldOut43",  32'(rst_n_out), 32'h7);
        if (e == 51) checkOutput("coldOut51",  32'(rst_n_out), 32'hf);
        if (e == 51) checkOutput("coldDone51", 32'(rst_done),  32'd0);
        if (e == 52) checkOutput("coldDone52", 32'(rst_done),  32'd1);
        if (e == 52) checkOutput("coldRun52",  32'(seq_state), 32'd3);
      end else begin
        if (e == 42) checkOutput("lateWait42", 32'(seq_state), 32'd1);
        if (e == 43) checkOutput("lateSeq43",  32'(seq_state), 32'd2);
        if (e == 50) checkOutput("lateOut50",  32'(rst_n_out), 32'h0);
        if (e == 51) checkOutput("lateOut51",  32'(rst_n_out), 32'h1);
        if (e == 59) checkOutput("lateOut59",  32'(rst_n_out), 32'h3);
        if (e == 76) checkOutput("lateRun76",  32'(seq_state), 32'd3);
      end
    end
  endtask

  // One cycle of random traffic: occasional lock drops, soft requests and full resets.
  task automatic applyStimulus();
    if (lockOff > 0) begin
      lockOff--;
      if (lockOff == 0) lock_in = 1'b1;
    end else if ($urandom_range(0, 299) == 0) begin
      lock_in = 1'b0;
      lockOff = $urandom_range(1, 8);
    end
    if (reqHold > 0) begin
      reqHold--;
      if (reqHold == 0) soft_rst_req = 1'b0;
    end else if ($urandom_range(0, 29) == 0) begin
      soft_rst_req  = 1'b1;
      soft_rst_mask = N'($urandom);
      reqHold       = $urandom_range(1, 40);
    end else if ($urandom_range(0, 3) == 0) begin
      soft_rst_mask = N'($urandom);
    end
    if ($urandom_range(0, 1499) == 0) begin
      holdReset();
      RSTn = 1'b1;
    end
    tick();
  endtask

  initial begin
    int softEntries;
    logic [2:0] prevSt;

    RSTn          = 1'b1;
    lock_in       = 1'b1;
    soft_rst_req  = 1'b0;
    soft_rst_mask = '0;
    modelReset();
    #2;
    holdReset();
    runColdStart(1'b0);

    $display("[TB] lock loss in RUN");
    lock_in = 1'b0;
    for (int r = 1; r <= 50; r++) begin
      tick();
      if (r == 5) lock_in = 1'b1;
      if (r == 2)  checkOutput("lossStill2", 32'(rst_n_out), 32'hf);
      if (r == 3)  checkOutput("lossOut3",   32'(rst_n_out), 32'h0);
      if (r == 3)  checkOutput("lossDone3",  32'(rst_done),  32'd0);
      if (r == 15) checkOutput("lossOut15",  32'(rst_n_out), 32'h0);
      if (r == 16) checkOutput("lossOut16",  32'(rst_n_out), 32'h1);
    end

    $display("[TB] soft reset mask 1010");
    soft_rst_req  = 1'b1;
    soft_rst_mask = 4'b1010;
    for (int r = 1; r <= 30; r++) begin
      tick();
      soft_rst_req = 1'b0;
      if (r == 1)  checkOutput("softOut1",   32'(rst_n_out), 32'h5);
      if (r == 1)  checkOutput("softState1", 32'(seq_state), 32'd4);
      if (r == 8)  checkOutput("softState8", 32'(seq_state), 32'd4);
      if (r == 9)  checkOutput("softSeq9",   32'(seq_state), 32'd2);
      if (r == 16) checkOutput("softOut16",  32'(rst_n_out), 32'h5);
      if (r == 17) checkOutput("softOut17",  32'(rst_n_out), 32'h7);
      if (r == 25) checkOutput("softOut25",  32'(rst_n_out), 32'hf);
      if (r == 26) checkOutput("softDone26", 32'(rst_done),  32'd1);
    end

    $display("[TB] zero-mask request");
    soft_rst_req  = 1'b1;
    soft_rst_mask = '0;
    tick();
    soft_rst_req = 1'b0;
    repeat (3) tick();
    checkOutput("zeroMaskState", 32'(seq_state), 32'd3);

    $display("[TB] request held high");
    soft_rst_req  = 1'b1;
    soft_rst_mask = 4'b0001;
    softEntries   = 0;
    prevSt        = seq_state;
    repeat (30) begin
      tick();
      if (seq_state == 3'd4 && prevSt != 3'd4) softEntries++;
      prevSt = seq_state;
    end
    checkOutput("heldOnce", 32'(softEntries), 32'd1);
    soft_rst_req = 1'b0;
    repeat (3) tick();

    $display("[TB] lock loss during SOFT");
    soft_rst_req  = 1'b1;
    soft_rst_mask = 4'b1100;
    tick();
    soft_rst_req = 1'b0;
    checkOutput("softLossEnter", 32'(seq_state), 32'd4);
    lock_in = 1'b0;
    repeat (3) tick();
    checkOutput("softLossState", 32'(seq_state), 32'd1);
    checkOutput("softLossOut",   32'(rst_n_out), 32'h0);
    lock_in = 1'b1;
    repeat (60) tick();
    checkOutput("softLossRun", 32'(seq_state), 32'd3);

    $display("[TB] late lock");
    holdReset();
    runColdStart(1'b1);

    $display("[TB] async reset mid-SEQ");
    holdReset();
    RSTn    = 1'b1;
    lock_in = 1'b1;
    for (int e = 1; e <= 36; e++) tick();
    checkOutput("midSeqOut", 32'(rst_n_out), 32'h3);
    holdReset();
    runColdStart(1'b0);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) applyStimulus();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
